// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the 8N1 UART receiver and transmitter.
//   - uart_state_t : FSM state encodings (S_IDLE .. S_BREAK)
//   - cycle_of     : clocks per bit, integer floor of CLK_FREQ / BOUD_RATE
//   - half_of      : clocks from the start-bit edge to mid start bit
//   - DATA_BITS, STOP_LEVEL : 8N1 frame constants
//   - CNT_W        : width of the bit-period counter
// ----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } uart_state_t;

   localparam int   DATA_BITS  = 8;
   localparam logic STOP_LEVEL = 1'b1;

   // 8 bits covers 234 clocks/bit (27 MHz, 115200 baud). Slower rates at
   // this clock overflow the counter; that limit is accepted, not checked.
   localparam int   CNT_W      = 8;

   function automatic int cycle_of(input int clk_freq, input int baud_rate);
      return clk_freq / baud_rate;
   endfunction

   function automatic int half_of(input int clk_freq, input int baud_rate);
      return cycle_of(clk_freq, baud_rate) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser that brings an asynchronous level into the clk domain.
// Both flops reset to RESET_VAL so an idle-high line does not look like a
// start bit when reset is released.
//   clk  in  system clock
//   rst  in  asynchronous, active-high reset
//   d    in  asynchronous input level
//   q    out synchronised level (two clocks of latency)
// ----------------------------------------------------------------------------
module uart_rx_sync
   import uart_pkg::*;
#(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// 8N1 asynchronous serial receiver. Oversamples rx_pin with clk, finds the
// mid-bit sample points from the start-bit falling edge and reports each byte
// with a one-cycle strobe. A stop bit sampled low raises frame_err and the
// receiver then waits for the line to return high, so a held-low line (break)
// is not decoded as a stream of 0x00 bytes.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BOUD_RATE  line rate in bit/s
// Ports
//   clk        in  system clock
//   rst        in  asynchronous, active-high reset
//   rx_pin     in  serial line, asynchronous, idles high
//   data       out last good byte, updated with valid, otherwise held
//   valid      out one-cycle pulse: frame completed with a good stop bit
//   frame_err  out one-cycle pulse: stop bit sampled low
//   busy       out high from start-bit detection until back in S_IDLE
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every sample is the 2-of-3 majority of
//                        rx_s at counter values HALF-1, HALF, HALF+1 (relative
//                        to the bit reference), so all sample points move one
//                        clock later. Undefined: single sample at HALF.
// ----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 27_000_000,
   parameter int BOUD_RATE = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int CYCLE = cycle_of(CLK_FREQ, BOUD_RATE);
   localparam int HALF  = half_of(CLK_FREQ, BOUD_RATE);

`ifdef UART_RX_MAJORITY_EN
   localparam int SAMPLE_SHIFT = 1;
`else
   localparam int SAMPLE_SHIFT = 0;
`endif

   // The counter holds the number of clocks elapsed since its reference edge
   // (it is loaded with 1 on the reference edge), so a compare value equals
   // the sample-point offset directly.
   localparam logic [CNT_W-1:0] START_AT = CNT_W'(HALF + SAMPLE_SHIFT);
   localparam logic [CNT_W-1:0] BIT_AT   = CNT_W'(CYCLE);
   localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

   logic             rx_s;
   logic             sample_bit;
   uart_state_t      state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;

   uart_rx_sync #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx_pin),
      .q   (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   // rx_hist[0] is rx_s one clock ago, rx_hist[1] two clocks ago. At the
   // sample edge (counter = HALF+1) these are the values at HALF and HALF-1.
   logic [1:0] rx_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_hist <= 2'b11;
      end else begin
         rx_hist <= {rx_hist[0], rx_s};
      end
   end

   assign sample_bit = (rx_hist[1] & rx_hist[0]) |
                       (rx_hist[1] & rx_s)       |
                       (rx_hist[0] & rx_s);
`else
   assign sample_bit = rx_s;
`endif

   // NOTE: all state below is updated with non-blocking assignments so every
   // branch reads the pre-edge values of cnt, state and shift_reg; blocking
   // assignments here would make results depend on statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the shift register is a handful of flops, not a memory, so it
         // is reset with everything else; this keeps data at 8'h00 after reset.
         state     <= S_IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         valid     <= 1'b0;
         frame_err <= 1'b0;

         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  cnt   <= CNT_W'(1);
                  busy  <= 1'b1;
                  state <= S_START;
               end
            end

            S_START: begin
               if (cnt == START_AT) begin
                  if (!sample_bit) begin
                     cnt     <= CNT_W'(1);
                     bit_idx <= '0;
                     state   <= S_DATA;
                  end else begin
                     // Start bit gone by mid-bit: a glitch, not a frame.
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_DATA: begin
               if (cnt == BIT_AT) begin
                  cnt       <= CNT_W'(1);
                  shift_reg <= {sample_bit, shift_reg[7:1]};
                  if (bit_idx == LAST_BIT) begin
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_STOP: begin
               if (cnt == BIT_AT) begin
                  if (sample_bit == STOP_LEVEL) begin
                     data  <= shift_reg;
                     valid <= 1'b1;
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= S_BREAK;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            S_BREAK: begin
               // Line must go idle before the next start edge can count.
               if (rx_s) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
